// File: rtl/memoria_pkg.sv
// Shared definitions for the memory-game controller.
// Card encoding: bits [4:2] symbol (0..7), bits [1:0] state (hidden, selected, matched).
// Holds the board types, card-state constants, winner encoding, the turn FSM state
// type and a helper that derives the winner from the two scores.
package memoria_pkg;

  localparam int N_CARTAS = 16;
  localparam int N_PARES  = 8;

  localparam logic [1:0] CARTA_OCULTA = 2'b00;
  localparam logic [1:0] CARTA_SEL    = 2'b01;
  localparam logic [1:0] CARTA_PAR    = 2'b10;

  localparam logic [1:0] GANA_J0 = 2'b00;
  localparam logic [1:0] GANA_J1 = 2'b01;
  localparam logic [1:0] EMPATE  = 2'b10;

  typedef logic [4:0] carta_t;
  typedef carta_t [0:N_CARTAS-1] tablero_t;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PICK1_GO   = 4'd1,
    ST_PICK1_WAIT = 4'd2,
    ST_PICK2_GO   = 4'd3,
    ST_PICK2_WAIT = 4'd4,
    ST_SHOW       = 4'd5,
    ST_RESOLVE    = 4'd6,
    ST_TIMEOUT    = 4'd7,
    ST_GAME_OVER  = 4'd8
  } estado_t;

  function automatic logic [1:0] calc_ganador(input logic [3:0] p0, input logic [3:0] p1);
    logic [1:0] g;
    if (p0 > p1) begin
      g = GANA_J0;
    end else if (p1 > p0) begin
      g = GANA_J1;
    end else begin
      g = EMPATE;
    end
    return g;
  endfunction

endpackage

// File: rtl/controlador_turnos_if.sv
// Handshake bundle between the turn controller and the card selector.
//   sel_start : controller -> selector, one-cycle pulse starting a selection round
//   arr_in    : controller -> selector, current board
//   sel_done  : selector -> controller, one-cycle done pulse
//   sel_arr   : selector -> controller, board with the newly selected card
interface controlador_turnos_if;
  import memoria_pkg::*;

  logic     sel_start;
  tablero_t arr_in;
  logic     sel_done;
  tablero_t sel_arr;

  modport master (output sel_start, output arr_in, input sel_done, input sel_arr);
  modport slave  (input sel_start, input arr_in, output sel_done, output sel_arr);

endinterface

// File: rtl/detector_cambio.sv
// Combinational search for the lowest card index whose encoding differs between two boards.
//   a_i, b_i : boards to compare
//   idx_o    : lowest differing index (0 when none)
//   valid_o  : high when at least one card differs
module detector_cambio
  import memoria_pkg::*;
(
  input  tablero_t   a_i,
  input  tablero_t   b_i,
  output logic [3:0] idx_o,
  output logic       valid_o
);

  // Scan from the top down so the lowest differing index is the last one written.
  always_comb begin
    idx_o   = 4'd0;
    valid_o = 1'b0;
    for (int i = N_CARTAS - 1; i >= 0; i--) begin
      idx_o   = (a_i[i] != b_i[i]) ? 4'(i) : idx_o;
      valid_o = valid_o | (a_i[i] != b_i[i]);
    end
  end

endmodule

// File: rtl/controlador_turnos.sv
// Turn controller for the 16-card memory game. Owns the board, requests two picks per
// turn from the selector, shows them, resolves match/mismatch, keeps two scores, enforces
// a per-turn timeout and reports the winner.
//   clk, rst      : clock, asynchronous active-low reset
//   start_game    : one-cycle pulse, (re)starts a game from tablero_init
//   sel_bus       : selector handshake (sel_start, arr_in, sel_done, sel_arr)
//   tablero       : current board (also fed to the renderer)
//   jugador       : player on turn
//   puntos_j0/j1  : pairs won per player
//   turno_timeout : one-cycle pulse when a turn expires
//   game_over     : high in the game-over state; ganador valid alongside it
module controlador_turnos
  import memoria_pkg::*;
#(
  parameter int TURN_CYCLES = 750_000_000,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_game,
  input  tablero_t                    tablero_init,
  controlador_turnos_if.master        sel_bus,
  output tablero_t                    tablero,
  output logic                        jugador,
  output logic [3:0]                  puntos_j0,
  output logic [3:0]                  puntos_j1,
  output logic                        turno_timeout,
  output logic                        game_over,
  output logic [1:0]                  ganador
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  estado_t       state_q, state_d;
  tablero_t      tablero_q, tablero_d;
  logic          jugador_q, jugador_d;
  logic [3:0]    p0_q, p0_d, p1_q, p1_d, pares_q, pares_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] show_q, show_d;
  logic [3:0]    idx1_q, idx1_d, idx2_q, idx2_d;
  logic          sel_start_q, sel_start_d, timeout_q, timeout_d, go_q, go_d;
  logic [1:0]    ganador_q, ganador_d;
  logic [3:0]    det_idx;
  logic          det_valid;

  detector_cambio u_det (
    .a_i     (tablero_q),
    .b_i     (sel_bus.sel_arr),
    .idx_o   (det_idx),
    .valid_o (det_valid)
  );

  // Next-state, board update and registered-output decode.
  always_comb begin
    state_d   = state_q;
    tablero_d = tablero_q;
    jugador_d = jugador_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    pares_d   = pares_q;
    timer_d   = timer_q;
    show_d    = show_q;
    idx1_d    = idx1_q;
    idx2_d    = idx2_q;
    if (start_game) begin
      tablero_d = tablero_init;
      p0_d      = 4'd0;
      p1_d      = 4'd0;
      jugador_d = 1'b0;
      pares_d   = 4'(N_PARES);
      timer_d   = '0;
      state_d   = ST_PICK1_GO;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_IDLE;
        // Timer is cleared on entry to a new turn, not here, so a retried first pick
        // keeps the turn clock running.
        ST_PICK1_GO:  state_d = ST_PICK1_WAIT;
        ST_PICK2_GO:  state_d = ST_PICK2_WAIT;
        ST_PICK1_WAIT, ST_PICK2_WAIT: begin
          timer_d = timer_q + TW'(1);
          if (sel_bus.sel_done) begin
            // No change, or a matched card picked: drop the result and ask again.
            if (!det_valid || (tablero_q[det_idx][1:0] == CARTA_PAR)) begin
              state_d = (state_q == ST_PICK1_WAIT) ? ST_PICK1_GO : ST_PICK2_GO;
            end else begin
              // Only state bits are taken from the selector; symbols stay as loaded.
              for (int i = 0; i < N_CARTAS; i++) begin
                tablero_d[i] = {tablero_q[i][4:2], sel_bus.sel_arr[i][1:0]};
              end
              if (state_q == ST_PICK1_WAIT) begin
                idx1_d  = det_idx;
                state_d = ST_PICK2_GO;
              end else begin
                idx2_d  = det_idx;
                show_d  = '0;
                state_d = ST_SHOW;
              end
            end
          end else if (timer_q == TW'(TURN_CYCLES - 1)) begin
            state_d = ST_TIMEOUT;
          end else begin
            state_d = state_q;
          end
        end
        ST_TIMEOUT: begin
          for (int i = 0; i < N_CARTAS; i++) begin
            tablero_d[i][1:0] = (tablero_q[i][1:0] == CARTA_SEL) ? CARTA_OCULTA : tablero_q[i][1:0];
          end
          jugador_d = ~jugador_q;
          timer_d   = '0;
          state_d   = ST_PICK1_GO;
        end
        ST_SHOW: begin
          if (show_q == SW'(SHOW_CYCLES - 1)) begin
            state_d = ST_RESOLVE;
          end else begin
            show_d = show_q + SW'(1);
          end
        end
        ST_RESOLVE: begin
          timer_d = '0;
          if (tablero_q[idx1_q][4:2] == tablero_q[idx2_q][4:2]) begin
            tablero_d[idx1_q][1:0] = CARTA_PAR;
            tablero_d[idx2_q][1:0] = CARTA_PAR;
            if (jugador_q) begin
              p1_d = (p1_q == 4'(N_PARES)) ? p1_q : p1_q + 4'd1;
            end else begin
              p0_d = (p0_q == 4'(N_PARES)) ? p0_q : p0_q + 4'd1;
            end
            pares_d = pares_q - 4'd1;
            state_d = (pares_q == 4'd1) ? ST_GAME_OVER : ST_PICK1_GO;
          end else begin
            tablero_d[idx1_q][1:0] = CARTA_OCULTA;
            tablero_d[idx2_q][1:0] = CARTA_OCULTA;
            jugador_d = ~jugador_q;
            state_d   = ST_PICK1_GO;
          end
        end
        ST_GAME_OVER: state_d = ST_GAME_OVER;
        default:      state_d = ST_IDLE;
      endcase
    end
    sel_start_d = (state_d == ST_PICK1_GO) || (state_d == ST_PICK2_GO);
    timeout_d   = (state_d == ST_TIMEOUT);
    go_d        = (state_d == ST_GAME_OVER);
    ganador_d   = go_d ? calc_ganador(p0_d, p1_d) : 2'b00;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tablero_q   <= '0;
      jugador_q   <= 1'b0;
      p0_q        <= 4'd0;
      p1_q        <= 4'd0;
      pares_q     <= 4'(N_PARES);
      timer_q     <= '0;
      show_q      <= '0;
      idx1_q      <= 4'd0;
      idx2_q      <= 4'd0;
      sel_start_q <= 1'b0;
      timeout_q   <= 1'b0;
      go_q        <= 1'b0;
      ganador_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      tablero_q   <= tablero_d;
      jugador_q   <= jugador_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      pares_q     <= pares_d;
      timer_q     <= timer_d;
      show_q      <= show_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
      sel_start_q <= sel_start_d;
      timeout_q   <= timeout_d;
      go_q        <= go_d;
      ganador_q   <= ganador_d;
    end
  end

  assign sel_bus.sel_start = sel_start_q;
  assign sel_bus.arr_in    = tablero_q;
  assign tablero           = tablero_q;
  assign jugador           = jugador_q;
  assign puntos_j0         = p0_q;
  assign puntos_j1         = p1_q;
  assign turno_timeout     = timeout_q;
  assign game_over         = go_q;
  assign ganador           = ganador_q;

endmodule
